// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC register and instruction fetch stage. Fetches words from
//               instruction memory over a req/ready handshake and hands them
//               to decode over a valid/ready handshake with PC and PC+4.
//               Execute redirects the PC through a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ir_valid_o,
    input  logic        ir_ready_i,
    output logic [31:0] ir_instr_o,
    output logic [31:0] ir_pc_o,
    output logic [31:0] ir_pc_plus4_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] ir_instr_q, ir_instr_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic [31:0] ir_pc_plus4_q, ir_pc_plus4_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state logic: redirect overrides both handshakes, so a word returned
    // or accepted in the redirect cycle is simply not acted upon.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_valid_d    = ir_valid_q;
        ir_instr_d    = ir_instr_q;
        ir_pc_d       = ir_pc_q;
        ir_pc_plus4_d = ir_pc_plus4_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid_i) begin
            pc_d       = {redirect_target_i[31:2], 2'b00};
            ir_valid_d = 1'b0;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_ready_i) begin
                        ir_instr_d    = imem_rdata_i;
                        ir_pc_d       = pc_q;
                        ir_pc_plus4_d = pc_plus4;
                        ir_valid_d    = 1'b1;
                        pc_d          = pc_plus4;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ir_ready_i) begin
                        ir_valid_d    = 1'b0;
                        fetch_count_d = fetch_count_q + 32'd1;
                        state_d       = S_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset that aborts any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_valid_q    <= 1'b0;
            ir_instr_q    <= 32'd0;
            ir_pc_q       <= 32'd0;
            ir_pc_plus4_q <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_valid_q    <= ir_valid_d;
            ir_instr_q    <= ir_instr_d;
            ir_pc_q       <= ir_pc_d;
            ir_pc_plus4_q <= ir_pc_plus4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // The request is a direct decode of the state register, so it only moves
    // on a clock edge; the address is the PC, which changes only outside S_REQ.
    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = pc_q;
    assign ir_valid_o    = ir_valid_q;
    assign ir_instr_o    = ir_instr_q;
    assign ir_pc_o       = ir_pc_q;
    assign ir_pc_plus4_o = ir_pc_plus4_q;
    assign fetch_count_o = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_instr;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_ready_i      (imem_ready),
        .imem_rdata_i      (imem_rdata),
        .ir_valid_o        (ir_valid),
        .ir_ready_i        (ir_ready),
        .ir_instr_o        (ir_instr),
        .ir_pc_o           (ir_pc),
        .ir_pc_plus4_o     (ir_pc_plus4),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .fetch_count_o     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at the text base, an
    // address-derived pattern everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Advance one edge and settle before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b0; ir_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", ir_valid); end
        checks++; if (ir_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %08h exp 00000000", ir_instr); end
        checks++; if (ir_pc !== 32'h0 || ir_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc got %08h/%08h exp 0/0", ir_pc, ir_pc_plus4); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rst_addr got %08h exp 00400000", imem_addr); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1; imem_ready = 1'b1; ir_ready = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || ir_valid !== 1'b0) begin errors++; $display("FAIL ff_req got req=%0h valid=%0h exp 1/0", imem_req, ir_valid); end
        tick();
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL ff_valid got %0h exp 1", ir_valid); end
        checks++; if (ir_instr !== 32'h2008_0005) begin errors++; $display("FAIL ff_instr got %08h exp 20080005", ir_instr); end
        checks++; if (ir_pc !== 32'h0040_0000 || ir_pc_plus4 !== 32'h0040_0004) begin errors++; $display("FAIL ff_pc got %08h/%08h exp 00400000/00400004", ir_pc, ir_pc_plus4); end
        checks++; if (imem_addr !== 32'h0040_0004 || imem_req !== 1'b0) begin errors++; $display("FAIL ff_next got addr=%08h req=%0h exp 00400004/0", imem_addr, imem_req); end
        tick();
        checks++; if (fetch_count !== 32'd1 || ir_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL ff_accept got cnt=%0d valid=%0h req=%0h exp 1/0/1", fetch_count, ir_valid, imem_req); end
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_instr !== mem_word(32'h0040_0004)) begin errors++; $display("FAIL ff_second got valid=%0h instr=%08h exp 1/%08h", ir_valid, ir_instr, mem_word(32'h0040_0004)); end
    endtask

    task automatic test_decode_stall();
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ir_valid !== 1'b1 || ir_pc !== 32'h0040_0004 || ir_pc_plus4 !== 32'h0040_0008 ||
                ir_instr !== mem_word(32'h0040_0004) || imem_req !== 1'b0 || fetch_count !== 32'd1) begin
                errors++;
                $display("FAIL stall_%0d got valid=%0h pc=%08h req=%0h cnt=%0d exp 1/00400004/0/1", i, ir_valid, ir_pc, imem_req, fetch_count);
            end
        end
        ir_ready = 1'b1;
        tick();
        checks++; if (fetch_count !== 32'd2 || ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL stall_accept got cnt=%0d valid=%0h req=%0h addr=%08h exp 2/0/1/00400008", fetch_count, ir_valid, imem_req, imem_addr); end
    endtask

    task automatic test_mem_wait();
        imem_ready = 1'b0; ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008 || ir_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_%0d got req=%0h addr=%08h valid=%0h exp 1/00400008/0", i, imem_req, imem_addr, ir_valid);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0040_0008 || ir_instr !== mem_word(32'h0040_0008)) begin errors++; $display("FAIL wait_capture got valid=%0h pc=%08h instr=%08h exp 1/00400008/%08h", ir_valid, ir_pc, ir_instr, mem_word(32'h0040_0008)); end
        ir_ready = 1'b1;
        tick();
        checks++; if (fetch_count !== 32'd3 || imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL wait_accept got cnt=%0d addr=%08h exp 3/0040000c", fetch_count, imem_addr); end
    endtask

    task automatic test_redirect();
        // In S_REQ with imem_ready high: the returned word must be dropped.
        redirect_valid = 1'b1; redirect_target = 32'h0040_0103;
        tick();
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0040_0100 || fetch_count !== 32'd3) begin errors++; $display("FAIL redir_req got valid=%0h req=%0h addr=%08h cnt=%0d exp 0/0/00400100/3", ir_valid, imem_req, imem_addr, fetch_count); end
        redirect_valid = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL redir_refetch got req=%0h addr=%08h exp 1/00400100", imem_req, imem_addr); end
        ir_ready = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0040_0100) begin errors++; $display("FAIL redir_capture got valid=%0h pc=%08h exp 1/00400100", ir_valid, ir_pc); end
        // In S_HOLD with ir_ready high: the handshake is void.
        ir_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        checks++; if (fetch_count !== 32'd3 || ir_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL redir_hold got cnt=%0d valid=%0h req=%0h addr=%08h exp 3/0/0/fffffffc", fetch_count, ir_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b0; ir_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%0h addr=%08h exp 1/fffffffc", imem_req, imem_addr); end
        tick();
        checks++; if (ir_pc !== 32'hFFFF_FFFC || ir_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got pc=%08h plus4=%08h addr=%08h exp fffffffc/0/0", ir_pc, ir_pc_plus4, imem_addr); end
    endtask

    task automatic test_reset_in_hold();
        ir_ready = 1'b1; rst_n = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b0 || ir_instr !== 32'h0 || ir_pc !== 32'h0 || ir_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rhold_out got valid=%0h req=%0h instr=%08h pc=%08h exp all 0", ir_valid, imem_req, ir_instr, ir_pc); end
        checks++; if (fetch_count !== 32'd0 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rhold_state got cnt=%0d addr=%08h exp 0/00400000", fetch_count, imem_addr); end
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rhold_restart got req=%0h addr=%08h exp 1/00400000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_mem_wait();
        test_redirect();
        test_wrap();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
